// File: rtl/vertex_pkg.sv
// Shared constants and FSM state encoding for the Y-axis vertex rotator.
// Sin/cos are fixed-point values scaled by 10^PRECISION.
package vertex_pkg;

    localparam int PRECISION = 6;
    localparam int SCALE     = 1000000;
    localparam int HALF      = 500000;

    localparam int COORD_W   = 11;
    localparam int OUT_W     = 12;
    localparam int TRIG_W    = 21;
    localparam int PROD_W    = COORD_W + TRIG_W;
    localparam int ACC_W     = 34;

    typedef enum logic [2:0] {
        IDLE,
        MUL,
        DIV_X,
        DIV_Z,
        OUT
    } state_t;

endpackage

// File: rtl/fixdiv_scale.sv
// Restoring divider: computes round(|dividend| / SCALE) with the dividend's sign.
// Produces one quotient bit per cycle, MSB first, over OUT_W-1 cycles.
module fixdiv_scale
    import vertex_pkg::*;
(
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic signed [ACC_W-1:0] dividend,
    output logic                    busy,
    output logic                    done,
    output logic signed [OUT_W-1:0] quotient
);

    localparam int Q_W = OUT_W - 1;

    logic [ACC_W-1:0] abs_div;
    logic [ACC_W-1:0] rem;
    logic [ACC_W-1:0] dsh;
    logic [ACC_W-1:0] rem_next;
    logic [Q_W-2:0]   q;
    logic [Q_W-1:0]   q_next;
    logic [3:0]       cnt;
    logic             neg;
    logic             ge;
    logic [OUT_W-1:0] mag;

    assign abs_div  = dividend[ACC_W-1] ? ACC_W'(-dividend) : ACC_W'(dividend);

    // Divisor aligned to the quotient bit under test in this cycle.
    assign dsh      = ACC_W'(SCALE) << (4'(Q_W - 1) - cnt);
    assign ge       = (rem >= dsh);
    assign rem_next = ge ? (rem - dsh) : rem;
    assign q_next   = {q, ge};

    assign done     = busy && (cnt == 4'(Q_W - 1));
    assign mag      = {1'b0, q_next};
    assign quotient = neg ? -$signed(mag) : $signed(mag);

    always_ff @(posedge clk) begin
        if (reset) begin
            busy <= 1'b0;
        end else if (start) begin
            busy <= 1'b1;
        end else if (done) begin
            busy <= 1'b0;
        end
    end

    // A start coinciding with the final iteration reloads for the next operand;
    // the finishing quotient is still visible combinationally that cycle.
    always_ff @(posedge clk) begin
        if (start) begin
            rem <= abs_div + ACC_W'(HALF);
            q   <= '0;
            cnt <= '0;
            neg <= dividend[ACC_W-1];
        end else if (busy) begin
            rem <= rem_next;
            q   <= q_next[Q_W-2:0];
            cnt <= cnt + 4'd1;
        end
    end

endmodule

// File: rtl/vertex_rotate_y.sv
// Rotates a vertex about the Y axis using one shared multiplier and a
// serial divider: x' = x*cos + z*sin, z' = z*cos - x*sin.
module vertex_rotate_y
    import vertex_pkg::*;
(
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic signed [COORD_W-1:0] x_in,
    input  logic signed [COORD_W-1:0] y_in,
    input  logic signed [COORD_W-1:0] z_in,
    input  logic signed [31:0]        sin_in,
    input  logic signed [31:0]        cos_in,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic signed [OUT_W-1:0]   x_out,
    output logic signed [OUT_W-1:0]   y_out,
    output logic signed [OUT_W-1:0]   z_out
);

    function automatic logic signed [TRIG_W-1:0] clamp_trig(input logic signed [31:0] v);
        if (v > SCALE) begin
            return TRIG_W'(SCALE);
        end else if (v < -SCALE) begin
            return TRIG_W'(-SCALE);
        end else begin
            return TRIG_W'(v);
        end
    endfunction

    state_t                     state;
    logic [1:0]                 mul_step;
    logic signed [COORD_W-1:0]  x_r, y_r, z_r;
    logic signed [TRIG_W-1:0]   sin_r, cos_r;
    logic signed [ACC_W-1:0]    acc_x, acc_z;

    logic signed [COORD_W-1:0]  mul_a;
    logic signed [TRIG_W-1:0]   mul_b;
    logic signed [PROD_W-1:0]   prod;
    logic signed [ACC_W-1:0]    prod_ext;

    logic                       accept;
    logic                       div_start;
    logic signed [ACC_W-1:0]    div_dividend;
    logic                       div_busy;
    logic                       div_done;
    logic                       div_fin;
    logic signed [OUT_W-1:0]    div_quot;

    assign accept = (state == IDLE) && in_valid && in_ready;

    // Step order: x*cos, z*sin, z*cos, x*sin.
    assign mul_a    = (mul_step[0] ^ mul_step[1]) ? z_r : x_r;
    assign mul_b    = mul_step[0] ? sin_r : cos_r;
    assign prod     = mul_a * mul_b;
    assign prod_ext = {{(ACC_W - PROD_W){prod[PROD_W-1]}}, prod};

    // acc_x is final after step 1 and acc_z after step 3, so each divide
    // is launched in the cycle before its DIV state begins.
    assign div_start    = ((state == MUL) && (mul_step == 2'd3)) ||
                          ((state == DIV_X) && div_fin);
    assign div_dividend = (state == MUL) ? acc_x : acc_z;
    assign div_fin      = div_busy && div_done;

    fixdiv_scale u_div (
        .clk      (clk),
        .reset    (reset),
        .start    (div_start),
        .dividend (div_dividend),
        .busy     (div_busy),
        .done     (div_done),
        .quotient (div_quot)
    );

    always_ff @(posedge clk) begin
        if (accept) begin
            x_r   <= x_in;
            y_r   <= y_in;
            z_r   <= z_in;
            sin_r <= clamp_trig(sin_in);
            cos_r <= clamp_trig(cos_in);
        end
        if (state == MUL) begin
            case (mul_step)
                2'd0:    acc_x <= prod_ext;
                2'd1:    acc_x <= acc_x + prod_ext;
                2'd2:    acc_z <= prod_ext;
                default: acc_z <= acc_z - prod_ext;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            mul_step  <= 2'd0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            x_out     <= '0;
            y_out     <= '0;
            z_out     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        state    <= MUL;
                        mul_step <= 2'd0;
                        in_ready <= 1'b0;
                    end
                end
                MUL: begin
                    mul_step <= mul_step + 2'd1;
                    if (mul_step == 2'd3) begin
                        state <= DIV_X;
                    end
                end
                DIV_X: begin
                    if (div_fin) begin
                        x_out <= div_quot;
                        state <= DIV_Z;
                    end
                end
                DIV_Z: begin
                    if (div_fin) begin
                        z_out     <= div_quot;
                        y_out     <= {y_r[COORD_W-1], y_r};
                        out_valid <= 1'b1;
                        state     <= OUT;
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vertex_rotate_y.sv
// Directed bench for vertex_rotate_y: rotation results, latency, rounding,
// clamping, backpressure and mid-operation reset.
module tb_vertex_rotate_y;

    logic               clk = 1'b0;
    logic               reset;
    logic               in_valid;
    logic               in_ready;
    logic signed [10:0] x_in, y_in, z_in;
    logic signed [31:0] sin_in, cos_in;
    logic               out_valid;
    logic               out_ready;
    logic signed [11:0] x_out, y_out, z_out;

    int n_tests = 0;
    int n_fail  = 0;
    int lat;

    always #5 clk = ~clk;

    vertex_rotate_y dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x_in      (x_in),
        .y_in      (y_in),
        .z_in      (z_in),
        .sin_in    (sin_in),
        .cos_in    (cos_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .x_out     (x_out),
        .y_out     (y_out),
        .z_out     (z_out)
    );

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Presents one vertex, lets it be accepted on the next rising edge.
    task automatic accept(input int x, input int y, input int z, input int s, input int c);
        @(negedge clk);
        in_valid = 1'b1;
        x_in     = x[10:0];
        y_in     = y[10:0];
        z_in     = z[10:0];
        sin_in   = s;
        cos_in   = c;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        check("busy_in_ready", in_ready, 0);
    endtask

    // Counts rising edges after the accepting edge until out_valid is seen.
    task automatic wait_out(output int edges);
        edges = 0;
        while (!out_valid && edges < 100) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
    endtask

    task automatic transfer();
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check("post_xfer_out_valid", out_valid, 0);
        check("post_xfer_in_ready", in_ready, 1);
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        x_in      = '0;
        y_in      = '0;
        z_in      = '0;
        sin_in    = '0;
        cos_in    = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_x_out", x_out, 0);
        check("rst_y_out", y_out, 0);
        check("rst_z_out", z_out, 0);

        // Identity rotation, with exact latency
        accept(100, 5, 0, 0, 1000000);
        wait_out(lat);
        check("ident_latency", lat, 26);
        check("ident_x", x_out, 100);
        check("ident_y", y_out, 5);
        check("ident_z", z_out, 0);
        transfer();

        // 90 degrees
        accept(100, 0, 0, 1000000, 0);
        wait_out(lat);
        check("r90_latency", lat, 26);
        check("r90_x", x_out, 0);
        check("r90_y", y_out, 0);
        check("r90_z", z_out, -100);
        transfer();

        // 30 degrees
        accept(1000, -7, 0, 500000, 866025);
        wait_out(lat);
        check("r30_x", x_out, 866);
        check("r30_y", y_out, -7);
        check("r30_z", z_out, -500);
        transfer();

        // Exact halves round away from zero
        accept(1, 0, 0, 0, 500000);
        wait_out(lat);
        check("half_pos_x", x_out, 1);
        check("half_pos_z", z_out, 0);
        transfer();
        accept(1, 0, 0, 0, -500000);
        wait_out(lat);
        check("half_neg_x", x_out, -1);
        transfer();

        // Out-of-range trig values are clamped to +/-SCALE
        accept(7, 3, 0, -3000000, 2000000);
        wait_out(lat);
        check("clamp_x", x_out, 7);
        check("clamp_z", z_out, 7);
        transfer();

        // Largest-magnitude corner
        accept(-1024, -1024, -1024, 707107, 707107);
        wait_out(lat);
        check("corner_latency", lat, 26);
        check("corner_x", x_out, -1448);
        check("corner_y", y_out, -1024);
        check("corner_z", z_out, 0);

        // Backpressure with a competing input that must be ignored
        in_valid = 1'b1;
        x_in     = 11'sd3;
        y_in     = 11'sd3;
        z_in     = 11'sd3;
        sin_in   = 0;
        cos_in   = 1000000;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            @(negedge clk);
            check("bp_out_valid", out_valid, 1);
            check("bp_in_ready", in_ready, 0);
            check("bp_x", x_out, -1448);
            check("bp_y", y_out, -1024);
            check("bp_z", z_out, 0);
        end
        in_valid = 1'b0;
        transfer();

        // Reset while the x division is in progress
        accept(1000, 9, 0, 500000, 866025);
        repeat (8) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_in_ready", in_ready, 1);
        check("midrst_x", x_out, 0);
        check("midrst_y", y_out, 0);
        check("midrst_z", z_out, 0);

        accept(0, 12, 100, 1000000, 0);
        wait_out(lat);
        check("after_rst_latency", lat, 26);
        check("after_rst_x", x_out, 100);
        check("after_rst_y", y_out, 12);
        check("after_rst_z", z_out, 0);
        transfer();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
